uart_input_handler: RTL and testbench
=====================================

# uart_input_handler

Receive-side ASCII command parser for the UART host bridge. Consumes one received byte per `byte_available` strobe, assembles a framed hex command into 32-bit command, address and data words, and pulses `ready` for one cycle when a complete frame has been parsed. Sits between the UART receiver and `wishbone_master`, which latches the three words on `ready`.

## Interface
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed between bytes mid-frame. Used only when `UART_INPUT_TIMEOUT_EN` is defined.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `byte_available`  in  1  single-cycle strobe; `byte` is valid in this cycle.
- `byte`  in  8  received ASCII character.
- `command`  out  32  parsed command word.
- `address`  out  32  parsed address word.
- `data`  out  32  parsed data word.
- `ready`  out  1  one-cycle pulse; the three output words are valid and new.

## Operation
- Frame format: start character `L` or `l`, then exactly 24 ASCII hex digits, MSB nibble first.
  - Digits 1-8 form `command`.
  - Digits 9-16 form `address`.
  - Digits 17-24 form `data`.
- Hex decode: `0`-`9` map to 0-9; `A`-`F` and `a`-`f` map to 10-15.
- States and transitions:
  - IDLE: waits for the start character. Every other byte is ignored, including CR, LF and space.
  - READ_CMD, READ_ADDR, READ_DATA: each state takes 8 digits, tracked by a 3-bit nibble counter. Each digit shifts into an internal shift register with `reg <= {reg[27:0], nibble}`.
- Frame completion: on the 24th digit, copy the shift registers to `command`, `address` and `data`, assert `ready`, and return to IDLE.
- Start character received mid-frame: restart the frame. Clear the shift registers and counter, then go to READ_CMD.
- Any other non-hex byte mid-frame: abort to IDLE. Do not pulse `ready` and leave the outputs unchanged.
- Outputs hold their last completed frame values until the next frame completes.
- Cycles where `byte_available` is low do not change state, except for a timeout when it is enabled.

## Timing
- Reset values:
  - `command`, `address`, `data` = 32'h0.
  - `ready` = 0.
  - State = IDLE, nibble counter = 0, shift registers = 0.
- `rst` has priority over a simultaneous `byte_available`; that byte is dropped.
- A reset mid-frame discards the partial frame. No `ready` is issued.
- `byte_available` may be high on consecutive cycles, one byte per cycle. No backpressure exists.
- Latency: `ready` and the updated outputs are registered and visible in the cycle after the clock edge that sampled the 24th digit.
- `ready` is high for exactly 1 cycle per completed frame.
- A start character arriving in the same cycle `ready` is high is accepted normally.
- Minimum frame-to-frame spacing is 25 byte strobes.

## Configuration
- `UART_INPUT_TIMEOUT_EN` defined:
  - A 32-bit counter increments every cycle while in READ_CMD, READ_ADDR or READ_DATA with `byte_available` low.
  - The counter clears on each strobe and in IDLE.
  - When the counter reaches `TIMEOUT_CYCLES`, the state returns to IDLE with no `ready` and outputs unchanged.
- `UART_INPUT_TIMEOUT_EN` undefined:
  - No counter is present.
  - A partial frame waits indefinitely for further bytes.

## Test plan
- Basic frame: after reset, send `L00000001000000100000ABCD`, one strobe every 6 cycles.
  - Expect `ready` for 1 cycle, `command` = 00000001, `address` = 00000010, `data` = 0000ABCD.
- Case and back-to-back: send `lDEADbeefCAFEF00D12345678` with strobes on consecutive cycles.
  - Expect `command` = DEADBEEF, `address` = CAFEF00D, `data` = 12345678 on the single `ready` pulse.
- Abort: send `L0000` then `G`, then a valid frame `L` with `11111111`, `22222222`, `33333333`.
  - Expect no `ready` after `G`; then `ready` with 11111111 / 22222222 / 33333333.
- Restart and noise: send CR/LF before `L`, then `L12L` followed by a full 24-digit frame of `A` digits.
  - Expect a single `ready` with all three words = AAAAAAAA.
- Reset mid-frame: assert `rst` for 1 cycle after 10 digits, then finish the remaining digits.
  - Expect no `ready` and all outputs = 0.
- Timeout (macro on, `TIMEOUT_CYCLES` = 20): send `L1234`, idle 25 cycles, then send 20 more digits.
  - Expect no `ready`.
  - With the macro off, the same stimulus produces `ready` with `command` = 12340000 (4-digit prefix plus the first 4 new digits, all `0`).

Source files
------------

// File: rtl/uart_input_handler.sv
// ============================================================================
// uart_input_handler
// ----------------------------------------------------------------------------
// Receive-side ASCII command parser for the UART host bridge.
//
// This block takes one received character per byte_available strobe and
// assembles a framed hex command into three 32-bit words. A frame is the
// start character 'L' or 'l', followed by exactly 24 ASCII hex digits. The
// most significant nibble comes first:
//   digits  1..8  -> command
//   digits  9..16 -> address
//   digits 17..24 -> data
//
// When the 24th digit is accepted, the three words are copied to the outputs
// and ready pulses for one cycle. wishbone_master latches the words on that
// pulse.
//
// Mid-frame behaviour:
//   - A start character restarts the frame from the first digit.
//   - Any other non-hex byte abandons the frame. No ready is issued and the
//     outputs keep their previous values.
//
// Optional feature, selected by the macro UART_INPUT_TIMEOUT_EN:
//   When the macro is defined, a partial frame is abandoned after
//   TIMEOUT_CYCLES consecutive cycles without a strobe. When it is
//   undefined, a partial frame waits indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles tolerated mid-frame (timeout build only)
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   byte_available  single-cycle strobe qualifying byte_in
//   byte_in         received ASCII character
//   command         parsed command word (held until the next frame)
//   address         parsed address word (held until the next frame)
//   data            parsed data word (held until the next frame)
//   ready           one-cycle pulse: the three words are new and valid
// ============================================================================
module uart_input_handler #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_available,
  input  logic [7:0]  byte_in,
  output logic [31:0] command,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic        ready
);

  typedef enum logic [1:0] {
    IDLE,
    READ_CMD,
    READ_ADDR,
    READ_DATA
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  nib_cnt_q, nib_cnt_d;
  logic [31:0] cmd_sr_q, cmd_sr_d;
  logic [31:0] addr_sr_q, addr_sr_d;
  logic [31:0] data_sr_q, data_sr_d;
  logic [31:0] command_q, command_d;
  logic [31:0] address_q, address_d;
  logic [31:0] data_q, data_d;
  logic        ready_q, ready_d;

  logic        is_start;
  logic        is_hex;
  logic [3:0]  nibble;
  logic [31:0] cmd_shift;
  logic [31:0] addr_shift;
  logic [31:0] data_shift;
  logic        last_nibble;

`ifdef UART_INPUT_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic [31:0] idle_cnt_inc;
`endif

  // Character classification and hex decode.
  // Digits map through their low nibble. 'A'-'F' and 'a'-'f' share the same
  // low nibble (1..6), so adding 9 gives 10..15 for either case.
  always_comb begin
    is_start = (byte_in == 8'h4C) || (byte_in == 8'h6C);
    is_hex   = 1'b0;
    nibble   = 4'h0;
    if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
      is_hex = 1'b1;
      nibble = byte_in[3:0];
    end else if ((byte_in >= 8'h41 && byte_in <= 8'h46) ||
                 (byte_in >= 8'h61 && byte_in <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = byte_in[3:0] + 4'd9;
    end
  end

  // Candidate shift-register values when a digit is accepted. The nibble
  // counter wraps from 7 back to 0, so each word always starts fresh.
  assign cmd_shift   = {cmd_sr_q[27:0], nibble};
  assign addr_shift  = {addr_sr_q[27:0], nibble};
  assign data_shift  = {data_sr_q[27:0], nibble};
  assign last_nibble = (nib_cnt_q == 3'd7);

`ifdef UART_INPUT_TIMEOUT_EN
  assign idle_cnt_inc = idle_cnt_q + 32'd1;
`endif

  // Next-state and datapath logic.
  // Every register holds by default. Only an accepted byte (or a timeout,
  // when that build option is enabled) moves the parser. The output words
  // change only on frame completion, so an abort or restart never disturbs
  // them.
  always_comb begin
    state_d   = state_q;
    nib_cnt_d = nib_cnt_q;
    cmd_sr_d  = cmd_sr_q;
    addr_sr_d = addr_sr_q;
    data_sr_d = data_sr_q;
    command_d = command_q;
    address_d = address_q;
    data_d    = data_q;
    ready_d   = 1'b0;
`ifdef UART_INPUT_TIMEOUT_EN
    idle_cnt_d = 32'd0;
`endif

    if (byte_available) begin
      if (is_start) begin
        // A start character begins a new frame in any state. In the
        // middle of a frame it throws away the partial frame.
        state_d   = READ_CMD;
        nib_cnt_d = 3'd0;
        cmd_sr_d  = 32'd0;
        addr_sr_d = 32'd0;
        data_sr_d = 32'd0;
      end else if (state_q != IDLE) begin
        if (is_hex) begin
          nib_cnt_d = nib_cnt_q + 3'd1;
          case (state_q)
            READ_CMD: begin
              cmd_sr_d = cmd_shift;
              if (last_nibble) begin
                state_d = READ_ADDR;
              end
            end
            READ_ADDR: begin
              addr_sr_d = addr_shift;
              if (last_nibble) begin
                state_d = READ_DATA;
              end
            end
            READ_DATA: begin
              data_sr_d = data_shift;
              if (last_nibble) begin
                // The final digit goes straight into the data output. The
                // shift register only holds the first 7 data digits at
                // this point.
                command_d = cmd_sr_q;
                address_d = addr_sr_q;
                data_d    = data_shift;
                ready_d   = 1'b1;
                state_d   = IDLE;
              end
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d   = IDLE;
          nib_cnt_d = 3'd0;
        end
      end
    end
`ifdef UART_INPUT_TIMEOUT_EN
    else if (state_q != IDLE) begin
      // Count quiet cycles inside a frame. When the count reaches the
      // limit, give up on the frame. The counter is cleared again when the
      // parser returns to IDLE.
      if (idle_cnt_inc >= TIMEOUT_CYCLES) begin
        state_d    = IDLE;
        nib_cnt_d  = 3'd0;
        idle_cnt_d = 32'd0;
      end else begin
        idle_cnt_d = idle_cnt_inc;
      end
    end
`endif
  end

  // State and datapath registers. A synchronous reset wins over a
  // strobe in the same cycle, so that byte is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      nib_cnt_q <= 3'd0;
      cmd_sr_q  <= 32'd0;
      addr_sr_q <= 32'd0;
      data_sr_q <= 32'd0;
      command_q <= 32'd0;
      address_q <= 32'd0;
      data_q    <= 32'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      nib_cnt_q <= nib_cnt_d;
      cmd_sr_q  <= cmd_sr_d;
      addr_sr_q <= addr_sr_d;
      data_sr_q <= data_sr_d;
      command_q <= command_d;
      address_q <= address_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
    end
  end

`ifdef UART_INPUT_TIMEOUT_EN
  // Inter-byte idle counter, present only in the timeout build.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= 32'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  assign command = command_q;
  assign address = address_q;
  assign data    = data_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_uart_input_handler.sv
// ============================================================================
// tb_uart_input_handler
// ----------------------------------------------------------------------------
// Self-checking bench for uart_input_handler.
//
// Contents:
//   - Directed frames: basic, mixed case, abort, restart, reset mid-frame,
//     and timeout. The timeout expectation depends on UART_INPUT_TIMEOUT_EN.
//   - A randomized section. It generates words, renders them as hex text in
//     random letter case, and surrounds them with noise, aborts and
//     restarts.
//
// Expected words come from the values the bench chose before rendering
// them as text. All inputs change on the falling edge, and all outputs are
// sampled on the falling edge.
// ============================================================================
module tb_uart_input_handler;

  logic        clk;
  logic        rst;
  logic        byte_available;
  logic [7:0]  byte_in;
  logic [31:0] command;
  logic [31:0] address;
  logic [31:0] data;
  logic        ready;

  int checks;
  int failures;
  int readyPulses;
  logic prevReady;

  logic [31:0] expCmd;
  logic [31:0] expAddr;
  logic [31:0] expData;
  int          expPulses;

  uart_input_handler #(
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .byte_available (byte_available),
    .byte_in        (byte_in),
    .command        (command),
    .address        (address),
    .data           (data),
    .ready          (ready)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: guarantees that the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to the next falling edge. Count ready pulses, and check that
  // no pulse lasts longer than one cycle.
  task automatic tick();
    @(negedge clk);
    if (ready === 1'b1) begin
      readyPulses++;
      checks++;
      assert (prevReady === 1'b0) else begin
        failures++;
        $error("[TB] FAIL ready_width observed=%0b expected=0", prevReady);
      end
    end
    prevReady = ready;
  endtask

  // Strobe one byte for one cycle, then leave `idle` quiet cycles after it.
  task automatic applyStimulus(input logic [7:0] b, input int idle);
    byte_available = 1'b1;
    byte_in        = b;
    tick();
    byte_available = 1'b0;
    repeat (idle) tick();
  endtask

  task automatic sendStr(input string s, input int idle);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(s[i], idle);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_pulses"}, readyPulses, expPulses);
    checkOutput({tag, "_command"}, command, expCmd);
    checkOutput({tag, "_address"}, address, expAddr);
    checkOutput({tag, "_data"}, data, expData);
  endtask

  function automatic logic [7:0] hexChar(input logic [3:0] n, input bit upper);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (upper ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  // Append the digits of one word, most significant nibble first.
  task automatic pushWord(inout logic [7:0] q[$], input logic [31:0] w);
    for (int i = 7; i >= 0; i--) begin
      q.push_back(hexChar(w[i*4 +: 4], 1'($urandom_range(0, 1))));
    end
  endtask

  task automatic sendQueue(input logic [7:0] q[$]);
    foreach (q[i]) applyStimulus(q[i], int'($urandom_range(0, 2)));
  endtask

  // Bytes that are neither hex digits nor start characters.
  logic [7:0] abortChars [7] = '{8'h47, 8'h7A, 8'h20, 8'h0D, 8'h0A, 8'h23, 8'h78};

  initial begin
    logic [7:0]  q[$];
    logic [31:0] w0, w1, w2;
    int          mode, k;
    logic [7:0]  b;

    checks         = 0;
    failures       = 0;
    readyPulses    = 0;
    prevReady      = 1'b0;
    expCmd         = 32'h0;
    expAddr        = 32'h0;
    expData        = 32'h0;
    expPulses      = 0;
    rst            = 1'b1;
    byte_available = 1'b0;
    byte_in        = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    checkAll("reset");
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);

    // Basic frame, one strobe every 6 cycles.
    sendStr("L00000001000000100000ABCD", 5);
    expPulses++; expCmd = 32'h00000001; expAddr = 32'h00000010; expData = 32'h0000ABCD;
    checkAll("basic");

    // Mixed case, strobes back to back. ready is due one cycle after the
    // last digit is sampled, and must then drop.
    sendStr("lDEADbeefCAFEF00D12345678", 0);
    checkOutput("latency_ready", {31'd0, ready}, 32'd1);
    expPulses++; expCmd = 32'hDEADBEEF; expAddr = 32'hCAFEF00D; expData = 32'h12345678;
    checkAll("case");
    tick();
    checkOutput("ready_drop", {31'd0, ready}, 32'd0);

    // Abort on a non-hex byte, then a valid frame.
    sendStr("L0000G", 1);
    tick();
    checkAll("abort");
    sendStr("L111111112222222233333333", 1);
    expPulses++; expCmd = 32'h11111111; expAddr = 32'h22222222; expData = 32'h33333333;
    checkAll("after_abort");

    // Noise before the start character, then a restart in mid-frame.
    sendStr("\r\nL12L", 0);
    sendStr("AAAAAAAAAAAAAAAAAAAAAAAA", 0);
    tick();
    expPulses++; expCmd = 32'hAAAAAAAA; expAddr = 32'hAAAAAAAA; expData = 32'hAAAAAAAA;
    checkAll("restart");

    // Reset after 10 digits. A start character strobed during the reset
    // cycle must be dropped, so the following 24 digits are ignored.
    sendStr("L0123456789", 0);
    rst = 1'b1; byte_available = 1'b1; byte_in = "L";
    tick();
    rst = 1'b0; byte_available = 1'b0;
    sendStr("012345678901234567890123", 0);
    tick();
    expCmd = 32'h0; expAddr = 32'h0; expData = 32'h0;
    checkAll("reset_mid");

    // Timeout: the frame is idle for 25 cycles in the middle of digits.
    sendStr("L1234", 0);
    repeat (25) tick();
    sendStr("00000000000000000000", 0);
    tick();
`ifndef UART_INPUT_TIMEOUT_EN
    expPulses++; expCmd = 32'h12340000; expAddr = 32'h0; expData = 32'h0;
`endif
    checkAll("timeout");

    // Randomized frames, aborts and restarts.
    for (int it = 0; it < 24; it++) begin
      q.delete();
      for (int n = 0; n < int'($urandom_range(0, 3)); n++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h4C || b == 8'h6C) b = 8'h20;
        q.push_back(b);
      end
      mode = int'($urandom_range(0, 2));
      w0 = $urandom; w1 = $urandom; w2 = $urandom;
      if (mode == 1) begin
        k = int'($urandom_range(0, 23));
        q.push_back($urandom_range(0, 1) ? 8'h4C : 8'h6C);
        for (int n = 0; n < k; n++) q.push_back(hexChar(4'($urandom), 1'($urandom_range(0, 1))));
        q.push_back(abortChars[$urandom_range(0, 6)]);
      end else begin
        if (mode == 2) begin
          k = int'($urandom_range(1, 23));
          q.push_back(8'h6C);
          for (int n = 0; n < k; n++) q.push_back(hexChar(4'($urandom), 1'($urandom_range(0, 1))));
        end
        q.push_back($urandom_range(0, 1) ? 8'h4C : 8'h6C);
        pushWord(q, w0);
        pushWord(q, w1);
        pushWord(q, w2);
        expPulses++; expCmd = w0; expAddr = w1; expData = w2;
      end
      sendQueue(q);
      tick();
      checkAll("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
